// File: rtl/rtc_bus_arbiter.sv
// Round-robin arbiter sharing the RTC bus-cycle engine between the write (W) and readback (R) sequencers.
// Optional WAIT timeout is enabled by defining ARB_TIMEOUT_EN.
module rtc_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  input  logic       rd_req,
  input  logic [7:0] rd_addr,
  output logic       rd_ack,
  output logic [7:0] rd_data,
  output logic       bus_start,
  output logic       bus_rw,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  input  logic       bus_done,
  input  logic [7:0] bus_rdata,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t     state_q, state_d;
  logic       last_r_q, last_r_d;
  logic       gnt_w_q, gnt_w_d;
  logic       wr_ack_q, wr_ack_d;
  logic       rd_ack_q, rd_ack_d;
  logic       err_q, err_d;
  logic       bus_start_q, bus_start_d;
  logic       busy_q, busy_d;
  logic       bus_rw_q, bus_rw_d;
  logic [7:0] bus_addr_q, bus_addr_d;
  logic [7:0] bus_wdata_q, bus_wdata_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       timeout;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter is cleared in ISSUE so every WAIT starts counting from zero.
  always_comb begin
    cnt_d   = cnt_q;
    timeout = 1'b0;
    if (state_q == S_ISSUE) begin
      cnt_d = '0;
    end else if (state_q == S_WAIT) begin
      cnt_d   = cnt_q + 1'b1;
      timeout = (cnt_d == CNT_W'(TIMEOUT_CYCLES));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    last_r_d    = last_r_q;
    gnt_w_d     = gnt_w_q;
    bus_rw_d    = bus_rw_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rd_data_d   = rd_data_q;
    wr_ack_d    = 1'b0;
    rd_ack_d    = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wr_req || rd_req) begin
          state_d     = S_ISSUE;
          // On a tie, W wins only if R was served last.
          gnt_w_d     = wr_req && (!rd_req || last_r_q);
          bus_rw_d    = gnt_w_d;
          bus_addr_d  = gnt_w_d ? wr_addr : rd_addr;
          bus_wdata_d = gnt_w_d ? wr_data : 8'h00;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (bus_done) begin
          state_d = S_RESP;
          if (!gnt_w_q) rd_data_d = bus_rdata;
        end else if (timeout) begin
          state_d = S_RESP;
          err_d   = 1'b1;
        end
        if (state_d == S_RESP) begin
          wr_ack_d = gnt_w_q;
          rd_ack_d = !gnt_w_q;
        end
      end
      S_RESP: begin
        state_d  = S_IDLE;
        last_r_d = !gnt_w_q;
      end
      default: state_d = S_IDLE;
    endcase
    bus_start_d = (state_d == S_ISSUE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      last_r_q    <= 1'b1;
      gnt_w_q     <= 1'b0;
      wr_ack_q    <= 1'b0;
      rd_ack_q    <= 1'b0;
      err_q       <= 1'b0;
      bus_start_q <= 1'b0;
      busy_q      <= 1'b0;
      bus_rw_q    <= 1'b0;
      bus_addr_q  <= 8'h00;
      bus_wdata_q <= 8'h00;
      rd_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      last_r_q    <= last_r_d;
      gnt_w_q     <= gnt_w_d;
      wr_ack_q    <= wr_ack_d;
      rd_ack_q    <= rd_ack_d;
      err_q       <= err_d;
      bus_start_q <= bus_start_d;
      busy_q      <= busy_d;
      bus_rw_q    <= bus_rw_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign wr_ack    = wr_ack_q;
  assign rd_ack    = rd_ack_q;
  assign err       = err_q;
  assign bus_start = bus_start_q;
  assign busy      = busy_q;
  assign bus_rw    = bus_rw_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Directed testbench for rtc_bus_arbiter; timeout scenario depends on ARB_TIMEOUT_EN.
module tb_rtc_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_req;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ack;
  logic       rd_req;
  logic [7:0] rd_addr;
  logic       rd_ack;
  logic [7:0] rd_data;
  logic       bus_start;
  logic       bus_rw;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_done;
  logic [7:0] bus_rdata;
  logic       busy;
  logic       err;

  int tests = 0;
  int fails = 0;

  rtc_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .bus_start(bus_start), .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_done(bus_done), .bus_rdata(bus_rdata), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_req = 1'b0; rd_req = 1'b0; wr_addr = 8'h00; wr_data = 8'h00;
    rd_addr = 8'h00; bus_done = 1'b0; bus_rdata = 8'h00;
    tick(); tick();
    tests++;
    if ({wr_ack, rd_ack, bus_start, busy, err, bus_rw} !== 6'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b, want 000000", {wr_ack, rd_ack, bus_start, busy, err, bus_rw});
    end
    tests++;
    if ({bus_addr, bus_wdata, rd_data} !== 24'h0) begin
      fails++; $display("FAIL reset_data: got %h, want 000000", {bus_addr, bus_wdata, rd_data});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    wr_req = 1'b1; wr_addr = 8'h21; wr_data = 8'h45;
    tick(); // cycle 1
    tests++;
    if ({bus_start, bus_rw, busy} !== 3'b111) begin
      fails++; $display("FAIL wr_issue: start/rw/busy got %b, want 111", {bus_start, bus_rw, busy});
    end
    tests++;
    if ({bus_addr, bus_wdata} !== 16'h2145) begin
      fails++; $display("FAIL wr_bus: addr/wdata got %h, want 2145", {bus_addr, bus_wdata});
    end
    tick(); // cycle 2
    tests++;
    if (bus_start !== 1'b0) begin
      fails++; $display("FAIL wr_start_len: got %b, want 0", bus_start);
    end
    for (int c = 3; c <= 4; c++) begin
      tick();
      tests++;
      if (wr_ack !== 1'b0) begin
        fails++; $display("FAIL wr_ack_early: cycle %0d got %b, want 0", c, wr_ack);
      end
    end
    bus_done = 1'b1; // cycle 4
    tick(); // cycle 5
    bus_done = 1'b0; wr_req = 1'b0;
    tests++;
    if ({wr_ack, rd_ack, err} !== 3'b100) begin
      fails++; $display("FAIL wr_ack: wr/rd/err got %b, want 100", {wr_ack, rd_ack, err});
    end
    tick(); // cycle 6
    tests++;
    if ({wr_ack, busy} !== 2'b00) begin
      fails++; $display("FAIL wr_end: ack/busy got %b, want 00", {wr_ack, busy});
    end
  endtask

  task automatic test_single_read();
    rd_req = 1'b1; rd_addr = 8'h42;
    tick(); // cycle 1
    tests++;
    if ({bus_start, bus_rw, bus_addr, bus_wdata} !== {1'b1, 1'b0, 8'h42, 8'h00}) begin
      fails++; $display("FAIL rd_issue: start=%b rw=%b addr=%h wdata=%h, want 1 0 42 00",
                        bus_start, bus_rw, bus_addr, bus_wdata);
    end
    tick(); // cycle 2: minimum latency
    bus_done = 1'b1; bus_rdata = 8'h37;
    tick(); // cycle 3
    bus_done = 1'b0; bus_rdata = 8'hEE; rd_req = 1'b0;
    tests++;
    if ({rd_ack, wr_ack, rd_data} !== {1'b1, 1'b0, 8'h37}) begin
      fails++; $display("FAIL rd_ack: rd_ack=%b wr_ack=%b data=%h, want 1 0 37", rd_ack, wr_ack, rd_data);
    end
    tick(); tick(); tick();
    tests++;
    if ({rd_ack, busy, rd_data} !== {1'b0, 1'b0, 8'h37}) begin
      fails++; $display("FAIL rd_hold: ack=%b busy=%b data=%h, want 0 0 37", rd_ack, busy, rd_data);
    end
  endtask

  task automatic test_round_robin();
    logic exp_w;
    int   n;
    reset = 1'b1;
    wr_req = 1'b1; wr_addr = 8'h10; wr_data = 8'hA5;
    rd_req = 1'b1; rd_addr = 8'h20;
    tick();
    reset = 1'b0;
    for (int t = 0; t < 4; t++) begin
      exp_w = (t % 2 == 0);
      n = 0;
      while (bus_start !== 1'b1 && n < 10) begin
        tick(); n++;
      end
      tests++;
      if (bus_start !== 1'b1) begin
        fails++; $display("FAIL rr_start_timeout: txn %0d got %b, want 1", t, bus_start);
      end
      tests++;
      if ({bus_rw, bus_addr, bus_wdata} !== (exp_w ? {1'b1, 8'h10, 8'hA5} : {1'b0, 8'h20, 8'h00})) begin
        fails++; $display("FAIL rr_grant: txn %0d rw=%b addr=%h wdata=%h, want rw=%b", t,
                          bus_rw, bus_addr, bus_wdata, exp_w);
      end
      tick();
      tests++;
      if (bus_start !== 1'b0) begin
        fails++; $display("FAIL rr_start_len: txn %0d got %b, want 0", t, bus_start);
      end
      tick(); tick();
      bus_done = 1'b1; bus_rdata = 8'h50 + 8'(t);
      tick();
      bus_done = 1'b0;
      if (t == 3) begin
        wr_req = 1'b0; rd_req = 1'b0;
      end
      tests++;
      if ({wr_ack, rd_ack} !== {exp_w, !exp_w}) begin
        fails++; $display("FAIL rr_ack: txn %0d wr/rd got %b%b, want %b%b", t, wr_ack, rd_ack, exp_w, !exp_w);
      end
      if (!exp_w) begin
        tests++;
        if (rd_data !== 8'h50 + 8'(t)) begin
          fails++; $display("FAIL rr_rdata: txn %0d got %h, want %h", t, rd_data, 8'h50 + 8'(t));
        end
      end
    end
    tick(); tick();
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL rr_idle: busy got %b, want 0", busy);
    end
  endtask

  task automatic test_stray_and_reset();
    bus_done = 1'b1;
    tick();
    bus_done = 1'b0;
    tests++;
    if ({wr_ack, rd_ack, busy, bus_start} !== 4'b0000) begin
      fails++; $display("FAIL stray_done: ack/ack/busy/start got %b, want 0000", {wr_ack, rd_ack, busy, bus_start});
    end
    wr_req = 1'b1; wr_addr = 8'h33; wr_data = 8'h99;
    tick(); tick(); // WAIT
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL mid_busy: got %b, want 1", busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0; wr_req = 1'b0;
    tests++;
    if ({busy, bus_start, wr_ack, bus_addr} !== {3'b000, 1'b0, 8'h00}) begin
      fails++; $display("FAIL mid_reset: busy=%b start=%b ack=%b addr=%h, want 0 0 0 00",
                        busy, bus_start, wr_ack, bus_addr);
    end
    tick();
    bus_done = 1'b1;
    tick();
    bus_done = 1'b0;
    tests++;
    if ({wr_ack, rd_ack, busy} !== 3'b000) begin
      fails++; $display("FAIL late_done: ack/ack/busy got %b, want 000", {wr_ack, rd_ack, busy});
    end
    tick();
  endtask

  task automatic test_timeout();
    wr_req = 1'b1; wr_addr = 8'h05; wr_data = 8'h0F;
    tick(); // cycle 1 ISSUE
`ifdef ARB_TIMEOUT_EN
    for (int c = 2; c <= 9; c++) begin
      tick();
      tests++;
      if ({wr_ack, err, busy} !== 3'b001) begin
        fails++; $display("FAIL to_wait: cycle %0d ack/err/busy got %b, want 001", c, {wr_ack, err, busy});
      end
    end
    tick(); // cycle 10 RESP
    wr_req = 1'b0;
    tests++;
    if ({wr_ack, err} !== 2'b11) begin
      fails++; $display("FAIL to_ack_err: ack/err got %b, want 11", {wr_ack, err});
    end
    tick();
    tests++;
    if ({wr_ack, err, busy} !== 3'b000) begin
      fails++; $display("FAIL to_end: ack/err/busy got %b, want 000", {wr_ack, err, busy});
    end
`else
    for (int c = 2; c < 102; c++) begin
      tick();
      tests++;
      if ({wr_ack, err, busy} !== 3'b001) begin
        fails++; $display("FAIL nto_wait: cycle %0d ack/err/busy got %b, want 001", c, {wr_ack, err, busy});
      end
    end
    bus_done = 1'b1;
    tick();
    bus_done = 1'b0; wr_req = 1'b0;
    tests++;
    if ({wr_ack, err} !== 2'b10) begin
      fails++; $display("FAIL nto_ack: ack/err got %b, want 10", {wr_ack, err});
    end
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_round_robin();
    test_stray_and_reset();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, want finish");
    $fatal(1, "timeout");
  end

endmodule
